// File: rtl/alu_pkg.sv
// alu_pkg: ALU opcode set, arbiter FSM states and default widths shared by the ALU arbiter.
package alu_pkg;
   localparam int ALU_DW  = 32;
   localparam int ALU_OPW = 4;
   typedef enum logic [3:0] {
      AND  = 4'b0000, OR   = 4'b0001, LUI  = 4'b0010, XOR  = 4'b0011,
      SLLI = 4'b0100, SRLI = 4'b0101, BLT  = 4'b0110, BGE  = 4'b0111,
      BEQ  = 4'b1000, BNE  = 4'b1001, SUB  = 4'b1010, ADD  = 4'b1011,
      SLT  = 4'b1100, SRAI = 4'b1101, JAL  = 4'b1110
   } alu_op_e;
   typedef enum logic [1:0] {IDLE, EXEC, RESP} arb_state_e;
endpackage

// File: rtl/alu_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker; grants the first valid index strictly after last_i.
module rr_pick #(
   parameter int NREQ = 2,
   localparam int IW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] valid_i,
   input  logic [IW-1:0]   last_i,
   output logic            any_o,
   output logic [NREQ-1:0] grant_oh_o,
   output logic [IW-1:0]   grant_idx_o
);
   logic [IW-1:0] c;
   // Scan from farthest to nearest so the nearest valid index after last_i wins.
   always_comb begin
      c = '0;
      grant_idx_o = '0;
      for (int k = NREQ; k >= 1; k--) begin
         c = IW'((int'(last_i) + k) % NREQ);
         if (valid_i[c]) grant_idx_o = c;
      end
   end
   assign any_o      = |valid_i;
   assign grant_oh_o = any_o ? NREQ'(1) << grant_idx_o : '0;
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one single-cycle ALU among NREQ requesters, one operation in flight.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH    = ALU_DW,
   parameter int OPCODE_LENGTH = ALU_OPW,
   parameter int NREQ          = 2
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NREQ-1:0]               req_valid,
   output logic [NREQ-1:0]               req_ready,
   input  logic [NREQ*DATA_WIDTH-1:0]    req_srca,
   input  logic [NREQ*DATA_WIDTH-1:0]    req_srcb,
   input  logic [NREQ*OPCODE_LENGTH-1:0] req_op,
   output logic [NREQ-1:0]               rsp_valid,
   input  logic [NREQ-1:0]               rsp_ready,
   output logic [DATA_WIDTH-1:0]         rsp_result,
   output logic [DATA_WIDTH-1:0]         alu_srca,
   output logic [DATA_WIDTH-1:0]         alu_srcb,
   output logic [OPCODE_LENGTH-1:0]      alu_op,
   input  logic [DATA_WIDTH-1:0]         alu_result
);
   localparam int IW = $clog2(NREQ);
   arb_state_e               state_q, state_d;
   logic [IW-1:0]            last_q, last_d, cur_q, cur_d, g;
   logic [DATA_WIDTH-1:0]    srca_q, srca_d, srcb_q, srcb_d, res_q, res_d;
   logic [OPCODE_LENGTH-1:0] op_q, op_d;
   logic                     any;
   logic [NREQ-1:0]          oh;

   rr_pick #(.NREQ(NREQ)) u_pick (
      .valid_i    (req_valid),
      .last_i     (last_q),
      .any_o      (any),
      .grant_oh_o (oh),
      .grant_idx_o(g)
   );

   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      cur_d     = cur_q;
      srca_d    = srca_q;
      srcb_d    = srcb_q;
      op_d      = op_q;
      res_d     = res_q;
      req_ready = '0;
      rsp_valid = '0;
      case (state_q)
         IDLE: if (any) begin
            req_ready = oh;
            srca_d    = req_srca[int'(g)*DATA_WIDTH +: DATA_WIDTH];
            srcb_d    = req_srcb[int'(g)*DATA_WIDTH +: DATA_WIDTH];
            op_d      = req_op[int'(g)*OPCODE_LENGTH +: OPCODE_LENGTH];
            cur_d     = g;
            last_d    = g;
            state_d   = EXEC;
         end
         EXEC: begin
            res_d   = alu_result;
            state_d = RESP;
         end
         RESP: begin
            rsp_valid[cur_q] = 1'b1;
            state_d          = rsp_ready[cur_q] ? IDLE : RESP;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         last_q  <= IW'(NREQ - 1);
         cur_q   <= '0;
         srca_q  <= '0;
         srcb_q  <= '0;
         op_q    <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         cur_q   <= cur_d;
         srca_q  <= srca_d;
         srcb_q  <= srcb_d;
         op_q    <= op_d;
         res_q   <= res_d;
      end
   end

   assign alu_srca   = srca_q;
   assign alu_srcb   = srcb_q;
   assign alu_op     = op_q;
   assign rsp_result = res_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized and directed checks of the ALU arbiter against a behavioural model.
module tb_alu_arbiter;
   import alu_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic [1:0]  valid2, ready2, rspv2, rspr2;
   logic [63:0] a2, b2;
   logic [7:0]  op2;
   logic [31:0] res2, alua2, alub2, alur2;
   logic [3:0]  aluop2;

   logic [3:0]   valid4, ready4, rspv4, rspr4;
   logic [127:0] a4, b4;
   logic [15:0]  op4;
   logic [31:0]  res4, alua4, alub4, alur4;
   logic [3:0]   aluop4;

   int passed = 0;
   int total  = 0;

   function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      case (alu_op_e'(op))
         AND:     return a & b;
         OR:      return a | b;
         LUI:     return b;
         XOR:     return a ^ b;
         SLLI:    return a << b[4:0];
         SRLI:    return a >> b[4:0];
         BLT:     return {31'b0, $signed(a) < $signed(b)};
         BGE:     return {31'b0, $signed(a) >= $signed(b)};
         BEQ:     return {31'b0, a == b};
         BNE:     return {31'b0, a != b};
         SUB:     return a - b;
         ADD:     return a + b;
         SLT:     return {31'b0, $signed(a) < $signed(b)};
         SRAI:    return $unsigned($signed(a) >>> b[4:0]);
         JAL:     return a + 32'd4;
         default: return 32'd0;
      endcase
   endfunction

   function automatic int rr_next(input int last, input logic [7:0] v, input int n);
      for (int k = 1; k <= n; k++) if (v[(last + k) % n]) return (last + k) % n;
      return -1;
   endfunction

   assign alur2 = alu_f(aluop2, alua2, alub2);
   assign alur4 = alu_f(aluop4, alua4, alub4);

   alu_arbiter #(.NREQ(2)) dut2 (
      .clk(clk), .reset(reset), .req_valid(valid2), .req_ready(ready2),
      .req_srca(a2), .req_srcb(b2), .req_op(op2), .rsp_valid(rspv2), .rsp_ready(rspr2),
      .rsp_result(res2), .alu_srca(alua2), .alu_srcb(alub2), .alu_op(aluop2), .alu_result(alur2)
   );

   alu_arbiter #(.NREQ(4)) dut4 (
      .clk(clk), .reset(reset), .req_valid(valid4), .req_ready(ready4),
      .req_srca(a4), .req_srcb(b4), .req_op(op4), .rsp_valid(rspv4), .rsp_ready(rspr4),
      .rsp_result(res4), .alu_srca(alua4), .alu_srcb(alub4), .alu_op(aluop4), .alu_result(alur4)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      valid2 = '0; rspr2 = '0; a2 = '0; b2 = '0; op2 = '0;
      valid4 = '0; rspr4 = '0; a4 = '0; b4 = '0; op4 = '0;
      #3;
      total++; if (ready2 !== 2'b00) $display("FAIL reset_ready got %b want 00", ready2); else passed++;
      total++; if (rspv2 !== 2'b00) $display("FAIL reset_rsp_valid got %b want 00", rspv2); else passed++;
      total++; if (res2 !== 32'd0) $display("FAIL reset_rsp_result got %h want 0", res2); else passed++;
      total++; if ({alua2, alub2, aluop2} !== 68'd0) $display("FAIL reset_alu got %h %h %h want 0", alua2, alub2, aluop2); else passed++;
      total++; if (rspv4 !== 4'b0000) $display("FAIL reset_rsp_valid4 got %b want 0000", rspv4); else passed++;
      cyc();
      cyc();
      reset = 1'b0;
      cyc();
   endtask

   task automatic test_add();
      valid2 = 2'b01; a2[31:0] = 32'd5; b2[31:0] = 32'd7; op2[3:0] = ADD; rspr2 = 2'b11;
      #1;
      total++; if (ready2 !== 2'b01) $display("FAIL add_ready got %b want 01", ready2); else passed++;
      cyc();
      valid2 = 2'b00;
      total++; if (rspv2 !== 2'b00) $display("FAIL add_exec_rsp got %b want 00", rspv2); else passed++;
      total++; if ({alua2, alub2, aluop2} !== {32'd5, 32'd7, ADD}) $display("FAIL add_alu_drive got %h %h %h want 5 7 b", alua2, alub2, aluop2); else passed++;
      cyc();
      total++; if (rspv2 !== 2'b01) $display("FAIL add_rsp_valid got %b want 01", rspv2); else passed++;
      total++; if (res2 !== 32'd12) $display("FAIL add_result got %0d want 12", res2); else passed++;
      cyc();
      total++; if (rspv2 !== 2'b00) $display("FAIL add_rsp_drop got %b want 00", rspv2); else passed++;
   endtask

   task automatic test_back_to_back();
      pulse_reset();
      valid2 = 2'b11; rspr2 = 2'b11;
      a2 = {32'hFFFF_FFFF, 32'd10}; b2 = {32'd1, 32'd3}; op2 = {SLT, SUB};
      #1;
      for (int i = 0; i < 4; i++) begin
         logic [1:0] w;
         logic [31:0] r;
         w = (i % 2 == 0) ? 2'b01 : 2'b10;
         r = (i % 2 == 0) ? 32'd7 : 32'd1;
         total++; if (ready2 !== w) $display("FAIL b2b_grant%0d got %b want %b", i, ready2, w); else passed++;
         cyc();
         cyc();
         total++; if (rspv2 !== w || res2 !== r) $display("FAIL b2b_rsp%0d got %b/%0d want %b/%0d", i, rspv2, res2, w, r); else passed++;
         cyc();
      end
      valid2 = 2'b00;
      cyc();
   endtask

   task automatic test_stall();
      pulse_reset();
      valid2 = 2'b10; a2 = {32'd2, 32'd9}; b2 = {32'd3, 32'd4}; op2 = {ADD, SUB}; rspr2 = 2'b01;
      #1;
      total++; if (ready2 !== 2'b10) $display("FAIL stall_grant1 got %b want 10", ready2); else passed++;
      cyc();
      valid2 = 2'b11;
      cyc();
      for (int i = 0; i < 5; i++) begin
         total++; if (rspv2 !== 2'b10) $display("FAIL stall_rsp_valid%0d got %b want 10", i, rspv2); else passed++;
         total++; if (res2 !== 32'd5) $display("FAIL stall_result%0d got %0d want 5", i, res2); else passed++;
         total++; if (ready2 !== 2'b00) $display("FAIL stall_ready%0d got %b want 00", i, ready2); else passed++;
         cyc();
      end
      rspr2 = 2'b10;
      #1;
      total++; if (rspv2 !== 2'b10 || ready2 !== 2'b00) $display("FAIL stall_release got %b/%b want 10/00", rspv2, ready2); else passed++;
      cyc();
      valid2 = 2'b01;
      #1;
      total++; if (ready2 !== 2'b01) $display("FAIL stall_next_grant got %b want 01", ready2); else passed++;
      cyc();
      valid2 = 2'b00; rspr2 = 2'b11;
      cyc();
      total++; if (rspv2 !== 2'b01 || res2 !== 32'd5) $display("FAIL stall_req0_rsp got %b/%0d want 01/5", rspv2, res2); else passed++;
      cyc();
   endtask

   task automatic test_reset_exec();
      valid2 = 2'b01; a2[31:0] = 32'hF0; b2[31:0] = 32'h0F; op2[3:0] = XOR; rspr2 = 2'b11;
      cyc();
      valid2 = 2'b00;
      total++; if (alua2 !== 32'hF0) $display("FAIL rst_exec_alu got %h want f0", alua2); else passed++;
      reset = 1'b1;
      #1;
      total++; if (rspv2 !== 2'b00 || ready2 !== 2'b00) $display("FAIL rst_exec_hs got %b/%b want 00/00", rspv2, ready2); else passed++;
      total++; if ({res2, alua2, alub2, aluop2} !== 100'd0) $display("FAIL rst_exec_outs got %h %h %h %h want 0", res2, alua2, alub2, aluop2); else passed++;
      cyc();
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         total++; if (rspv2 !== 2'b00) $display("FAIL rst_exec_norsp%0d got %b want 00", i, rspv2); else passed++;
      end
      valid2 = 2'b11; a2 = {32'd1, 32'd1}; b2 = {32'd1, 32'd1}; op2 = {ADD, ADD};
      #1;
      total++; if (ready2 !== 2'b01) $display("FAIL rst_exec_first_grant got %b want 01", ready2); else passed++;
      cyc();
      valid2 = 2'b00;
      cyc();
      cyc();
   endtask

   task automatic test_opcodes();
      logic [3:0]  ops [2] = '{4'b1111, SRAI};
      logic [31:0] as [2] = '{32'd3, 32'h8000_0000};
      logic [31:0] bs [2] = '{32'd4, 32'd4};
      logic [31:0] ex [2] = '{32'd0, 32'hF800_0000};
      rspr2 = 2'b11;
      for (int i = 0; i < 2; i++) begin
         valid2 = 2'b01; op2[3:0] = ops[i]; a2[31:0] = as[i]; b2[31:0] = bs[i];
         #1;
         total++; if (ready2 !== 2'b01) $display("FAIL op%0d_grant got %b want 01", i, ready2); else passed++;
         cyc();
         valid2 = 2'b00;
         cyc();
         total++; if (rspv2 !== 2'b01 || res2 !== ex[i]) $display("FAIL op%0d_result got %b/%h want 01/%h", i, rspv2, res2, ex[i]); else passed++;
         cyc();
      end
   endtask

   task automatic test_random();
      logic [1:0]  pend;
      logic [31:0] pa [2];
      logic [31:0] pb [2];
      logic [3:0]  po [2];
      int last_m;
      pulse_reset();
      pend = 2'b00; last_m = 1; rspr2 = 2'b00;
      for (int n = 0; n < 30; n++) begin
         int e;
         int stall;
         logic [31:0] want;
         for (int r = 0; r < 2; r++) begin
            if (!pend[r] && ($urandom_range(0, 1) == 1 || (pend == 2'b00 && r == 1))) begin
               pend[r] = 1'b1; pa[r] = $urandom; pb[r] = $urandom; po[r] = 4'($urandom_range(0, 15));
            end
         end
         valid2 = pend;
         a2 = {pa[1], pa[0]}; b2 = {pb[1], pb[0]}; op2 = {po[1], po[0]};
         #1;
         e = rr_next(last_m, {6'b0, pend}, 2);
         want = alu_f(po[e], pa[e], pb[e]);
         total++; if (ready2 !== 2'(1 << e)) $display("FAIL rnd%0d_grant got %b want %b", n, ready2, 2'(1 << e)); else passed++;
         cyc();
         pend[e] = 1'b0; last_m = e;
         valid2 = pend;
         rspr2 = 2'($urandom_range(0, 3));
         rspr2[e] = 1'b0;
         #1;
         total++; if (rspv2 !== 2'b00 || alua2 !== pa[e] || aluop2 !== po[e]) $display("FAIL rnd%0d_exec got %b %h %h want 00 %h %h", n, rspv2, alua2, aluop2, pa[e], po[e]); else passed++;
         cyc();
         stall = $urandom_range(0, 3);
         for (int s = 0; s < stall; s++) begin
            total++; if (rspv2 !== 2'(1 << e) || res2 !== want || ready2 !== 2'b00) $display("FAIL rnd%0d_stall%0d got %b/%h/%b want %b/%h/00", n, s, rspv2, res2, ready2, 2'(1 << e), want); else passed++;
            cyc();
         end
         rspr2[e] = 1'b1;
         #1;
         total++; if (rspv2 !== 2'(1 << e) || res2 !== want) $display("FAIL rnd%0d_rsp got %b/%h want %b/%h", n, rspv2, res2, 2'(1 << e), want); else passed++;
         cyc();
      end
      valid2 = 2'b00; rspr2 = 2'b11;
      cyc();
      cyc();
      cyc();
   endtask

   task automatic test_fair4();
      int waited [4] = '{0, 0, 0, 0};
      pulse_reset();
      for (int r = 0; r < 4; r++) begin
         a4[r*32 +: 32] = $urandom; b4[r*32 +: 32] = $urandom; op4[r*4 +: 4] = 4'($urandom_range(0, 14));
      end
      valid4 = 4'b1111; rspr4 = 4'b1111;
      #1;
      for (int i = 0; i < 5; i++) begin
         int e;
         int obs;
         logic [31:0] want;
         e = i % 4;
         obs = -1;
         for (int r = 0; r < 4; r++) if (ready4 == 4'(1 << r)) obs = r;
         for (int r = 0; r < 4; r++) waited[r] = (r == obs) ? 0 : waited[r] + 1;
         want = alu_f(op4[e*4 +: 4], a4[e*32 +: 32], b4[e*32 +: 32]);
         total++; if (ready4 !== 4'(1 << e)) $display("FAIL fair%0d_grant got %b want %b", i, ready4, 4'(1 << e)); else passed++;
         total++; if (waited[0] > 3 || waited[1] > 3 || waited[2] > 3 || waited[3] > 3) $display("FAIL fair%0d_wait got %0d %0d %0d %0d want <=3", i, waited[0], waited[1], waited[2], waited[3]); else passed++;
         cyc();
         cyc();
         total++; if (rspv4 !== 4'(1 << e) || res4 !== want) $display("FAIL fair%0d_rsp got %b/%h want %b/%h", i, rspv4, res4, 4'(1 << e), want); else passed++;
         cyc();
      end
      valid4 = 4'b0000;
      cyc();
   endtask

   initial begin
      test_reset();
      test_add();
      test_back_to_back();
      test_stall();
      test_reset_exec();
      test_opcodes();
      test_random();
      test_fair4();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter and sequencer sharing one single-cycle ALU among `NREQ` requesters (e.g. the integer pipeline and a branch/address helper). Each requester hands over one operation (operands and 4-bit ALU opcode) through a valid/ready handshake. The arbiter registers the operation, drives the shared ALU for one cycle, and returns the captured result on that requester's response channel. The block sits between the requesters and the ALU's `SrcA`/`SrcB`/`Operation`/`ALUResult` ports and contains no arithmetic of its own.

## Interface
- `DATA_WIDTH`, 32, operand/result width; matches the ALU.
- `OPCODE_LENGTH`, 4, ALU opcode width.
- `NREQ`, 2, number of requesters; legal range 2..8.
- `clk`  in  1  Clock. One clock domain, rising edge.
- `reset`  in  1  Asynchronous reset, active-high.
- `req_valid`  in  NREQ  Per-requester operation valid.
- `req_ready`  out  NREQ  Per-requester accept; at most one bit set.
- `req_srca`  in  NREQ×DATA_WIDTH  Operand A per requester.
- `req_srcb`  in  NREQ×DATA_WIDTH  Operand B per requester.
- `req_op`  in  NREQ×OPCODE_LENGTH  ALU opcode per requester.
- `rsp_valid`  out  NREQ  Per-requester result valid; at most one bit set.
- `rsp_ready`  in  NREQ  Per-requester result accept.
- `rsp_result`  out  DATA_WIDTH  Result, shared by all requesters; qualified by `rsp_valid`.
- `alu_srca`, `alu_srcb`  out  DATA_WIDTH  To ALU `SrcA`/`SrcB`.
- `alu_op`  out  OPCODE_LENGTH  To ALU `Operation`.
- `alu_result`  in  DATA_WIDTH  From ALU `ALUResult`.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: if any `req_valid` is set, the round-robin picker selects the first valid requester strictly after `last_grant`, wrapping modulo NREQ. It asserts `req_ready[g]` combinationally in the same cycle. On that edge the block latches srca/srcb/op into operand registers, latches `g` into `cur`, sets `last_grant <= g`, and moves to EXEC. If no request is valid, it stays in IDLE.
- EXEC: the operand registers drive `alu_*`. At the end of the cycle `alu_result` is captured into `res_q`, and the state moves to RESP.
- RESP: `rsp_valid[cur]=1`, `rsp_result=res_q`. Leaves for IDLE on the edge where `rsp_ready[cur]=1`. `rsp_ready` of other requesters is ignored.
- `req_ready` is 0 in EXEC and RESP. No pipelining; one operation is in flight.
- `alu_*` outputs always reflect the operand registers (held outside EXEC). They are not gated.
- Opcodes pass through unchecked. The unused code 4'b1111 yields whatever the ALU returns (0).
- A requester must hold `req_valid` and its payload stable until `req_ready`. Behaviour when this is violated is undefined.
- Simultaneous events: `rsp_ready` and new `req_valid` arrive in RESP → the new request is granted in the following IDLE cycle, never in RESP.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,NREQ-1,0. The maximum wait is NREQ-1 operations.

## Timing
- Reset (asynchronous, any state): state=IDLE, `last_grant=NREQ-1` (requester 0 wins first), `cur=0`, operand registers and `res_q` = 0. `req_ready` then follows IDLE arbitration; `rsp_valid=0`, `rsp_result=0`, `alu_srca=alu_srcb=0`, `alu_op=0`.
- Reset mid-operation drops the in-flight operation. No response is issued.
- Latency: accept on edge N, ALU evaluated during N+1, `rsp_valid` high from after edge N+1 (second cycle after acceptance).
- Minimum issue interval is 3 cycles per operation with `rsp_ready` tied high. `rsp_ready` low stalls in RESP indefinitely, and `rsp_result` holds stable.

## Structure
- Package `alu_pkg`:
  - `alu_op_e` enum: AND=0000, OR=0001, LUI=0010, XOR=0011, SLLI=0100, SRLI=0101, BLT=0110, BGE=0111, BEQ=1000, BNE=1001, SUB=1010, ADD=1011, SLT=1100, SRAI=1101, JAL=1110.
  - `arb_state_e` enum: IDLE, EXEC, RESP.
  - Width constants.
- Sub-module `rr_pick`: combinational, parameterized by NREQ. Takes a `valid` vector and `last` index and returns `any` plus a one-hot/index grant. It is reusable for other shared resources.
- The ALU itself is instantiated by the parent, not inside this block.

## Test plan
- After reset, req0 sends ADD (1011) with 5, 7 → `req_ready[0]` in the same cycle. `rsp_valid[0]` is asserted 2 cycles after acceptance, with `rsp_result=12`.
- req0 and req1 are valid together from reset, req0 SUB 10−3 and req1 SLT −1<1 → req0 granted first and returns 7. Then req1 returns 1. Grant order over 4 back-to-back ops is 0,1,0,1.
- `rsp_ready[1]` is held low for 5 cycles in RESP with req0 valid → state stays RESP, `rsp_result` stays constant, and `req_ready[0]` stays 0 until release. req0 is granted the cycle after release.
- Reset is pulsed during EXEC of XOR 0xF0^0x0F → no `rsp_valid`. All outputs are 0, and the next grant goes to requester 0.
- Opcode 1111 with 3, 4 → `rsp_result=0`. SRAI 0x80000000 by 4 → 0xF8000000.
- NREQ=4, all valid continuously → grants 0,1,2,3,0. No requester waits more than 3 operations.
